// File: rtl/test_pattern_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | test_pattern_generator                                                   |
// | Raster timing plus nine frame-synchronous test patterns, registered out. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module test_pattern_generator #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FRONT    = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BACK     = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FRONT    = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BACK     = 20,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned BAR_W      = 16,
  parameter int unsigned BAR_STEP   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] pattern,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // h is at least 8 bits wide so the grey ramp can take h[7:0] directly.
  localparam int unsigned HW_MIN = (CHECK_LOG2 + 1 > 8) ? CHECK_LOG2 + 1 : 8;
  localparam int unsigned HW     = ($clog2(H_TOTAL + 1) > HW_MIN) ? $clog2(H_TOTAL + 1) : HW_MIN;
  localparam int unsigned VW     = ($clog2(V_TOTAL + 1) > CHECK_LOG2 + 1) ?
                                   $clog2(V_TOTAL + 1) : CHECK_LOG2 + 1;
  localparam int unsigned HW1    = HW + 1;
  localparam int unsigned BAR_PX = H_ACTIVE / 8;
  localparam int unsigned BPW    = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  localparam logic [HW-1:0]  H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT       = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_START    = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0]  HS_END      = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]  V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT       = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_START    = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0]  VS_END      = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [BPW-1:0] BAR_PX_LAST = BPW'(BAR_PX - 1);
  localparam logic [HW1-1:0] STEP_X      = HW1'(BAR_STEP);
  localparam logic [HW1-1:0] BAR_W_X     = HW1'(BAR_W);
  localparam logic [HW1-1:0] H_ACT_X     = HW1'(H_ACTIVE);

  localparam logic [23:0] WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] BLACK = 24'h00_00_00;
  localparam logic [3:0]  RESET_PATTERN = 4'd4;

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [BPW-1:0] bar_px_q, bar_px_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic [3:0]     active_pattern_q, active_pattern_d;
  logic [HW1-1:0] bar_pos_q, bar_pos_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [23:0]    rgb_q, rgb_d;

  logic           h_wrap;
  logic           frame_end;
  logic           active;
  logic           in_bar;
  logic [HW1-1:0] bar_sum;
  logic [HW1-1:0] h_x;
  logic [23:0]    pixel;

  always_comb begin
    h_wrap    = (h_q == H_LAST);
    frame_end = h_wrap && (v_q == V_LAST);
    active    = (h_q < H_ACT) && (v_q < V_ACT);
    h_x       = {1'b0, h_q};
    in_bar    = (h_x >= bar_pos_q) && (h_x < bar_pos_q + BAR_W_X);
    bar_sum   = bar_pos_q + STEP_X;

    h_d = h_wrap ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    // Colour-bar index tracks h/BAR_PX incrementally instead of dividing.
    bar_px_d  = bar_px_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_PX_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end

    active_pattern_d = active_pattern_q;
    bar_pos_d        = bar_pos_q;
    if (frame_end) begin
      active_pattern_d = pattern;
      bar_pos_d        = (bar_sum >= H_ACT_X) ? bar_sum - H_ACT_X : bar_sum;
    end

    case (active_pattern_q)
      4'd1:    pixel = WHITE;
      4'd2:    pixel = 24'hFF_00_00;
      4'd3:    pixel = 24'h00_FF_00;
      4'd4:    pixel = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
      4'd5:    pixel = 24'h00_00_FF;
      4'd6:    pixel = {h_q[7:0], h_q[7:0], h_q[7:0]};
      4'd7:    pixel = (h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2]) ? BLACK : WHITE;
      4'd8:    pixel = in_bar ? WHITE : BLACK;
      default: pixel = BLACK;
    endcase

    hsync_d = (h_q >= HS_START) && (h_q < HS_END);
    vsync_d = (v_q >= VS_START) && (v_q < VS_END);
    de_d    = active;
    rgb_d   = active ? pixel : BLACK;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q              <= '0;
      v_q              <= '0;
      bar_px_q         <= '0;
      bar_idx_q        <= '0;
      active_pattern_q <= RESET_PATTERN;
      bar_pos_q        <= '0;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      de_q             <= 1'b0;
      rgb_q            <= '0;
    end else begin
      h_q              <= h_d;
      v_q              <= v_d;
      bar_px_q         <= bar_px_d;
      bar_idx_q        <= bar_idx_d;
      active_pattern_q <= active_pattern_d;
      bar_pos_q        <= bar_pos_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      de_q             <= de_d;
      rgb_q            <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign r     = rgb_q[23:16];
  assign g     = rgb_q[15:8];
  assign b     = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_test_pattern_generator                                                |
// | Directed vector bench for the test pattern generator (small raster).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_test_pattern_generator;

  localparam int HT = 22;
  localparam int VT = 11;
  localparam int FRAME = HT * VT;

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
  } pix_vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] pattern = 4'd4;
  logic       hsync, vsync, de;
  logic [7:0] r, g, b;

  logic [23:0] cap_rgb [VT][HT];
  logic        cap_de  [VT][HT];
  logic        cap_hs  [VT][HT];
  logic        cap_vs  [VT][HT];

  int n_checks = 0;
  int n_errors = 0;

  pix_vec_t bars_tbl [16];
  pix_vec_t chk_tbl  [12];
  logic [15:0] bar_mask_tbl [4];

  always #5 clk = ~clk;

  test_pattern_generator #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CHECK_LOG2(2), .BAR_W(4), .BAR_STEP(4)
  ) dut (
    .clk(clk), .resetn(resetn), .pattern(pattern),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Captures n_steps output pixels starting at (0,0); new_pat is driven after step change_at.
  task automatic run_frame(input int n_steps, input logic [3:0] new_pat, input int change_at);
    for (int i = 0; i < n_steps; i++) begin
      @(posedge clk);
      #1;
      cap_rgb[i / HT][i % HT] = {r, g, b};
      cap_de[i / HT][i % HT]  = de;
      cap_hs[i / HT][i % HT]  = hsync;
      cap_vs[i / HT][i % HT]  = vsync;
      if (i == change_at) pattern = new_pat;
    end
  endtask

  task automatic check_raster(input string tag);
    int de_cnt;
    int bad;
    de_cnt = 0;
    bad = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (cap_de[v][h]) de_cnt++;
        if (cap_de[v][h] !== (h < 16 && v < 8)) bad++;
        if (cap_hs[v][h] !== (h == 18 || h == 19)) bad++;
        if (cap_vs[v][h] !== (v == 9)) bad++;
        if (!cap_de[v][h] && cap_rgb[v][h] !== 24'h0) bad++;
      end
    end
    check({tag, "_de_count"}, de_cnt, 128);
    check({tag, "_timing"}, bad, 0);
  endtask

  task automatic check_bars_line0(input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_bar_h%0d", tag, bars_tbl[i].h),
            cap_rgb[bars_tbl[i].v][bars_tbl[i].h], bars_tbl[i].rgb);
    end
  endtask

  initial begin
    bars_tbl[0]  = '{0, 0, 24'hFFFFFF};  bars_tbl[1]  = '{1, 0, 24'hFFFFFF};
    bars_tbl[2]  = '{2, 0, 24'hFFFF00};  bars_tbl[3]  = '{3, 0, 24'hFFFF00};
    bars_tbl[4]  = '{4, 0, 24'h00FFFF};  bars_tbl[5]  = '{5, 0, 24'h00FFFF};
    bars_tbl[6]  = '{6, 0, 24'h00FF00};  bars_tbl[7]  = '{7, 0, 24'h00FF00};
    bars_tbl[8]  = '{8, 0, 24'hFF00FF};  bars_tbl[9]  = '{9, 0, 24'hFF00FF};
    bars_tbl[10] = '{10, 0, 24'hFF0000}; bars_tbl[11] = '{11, 0, 24'hFF0000};
    bars_tbl[12] = '{12, 0, 24'h0000FF}; bars_tbl[13] = '{13, 0, 24'h0000FF};
    bars_tbl[14] = '{14, 0, 24'h000000}; bars_tbl[15] = '{15, 0, 24'h000000};

    chk_tbl[0]  = '{0, 0, 24'hFFFFFF};  chk_tbl[1]  = '{3, 0, 24'hFFFFFF};
    chk_tbl[2]  = '{4, 0, 24'h000000};  chk_tbl[3]  = '{7, 0, 24'h000000};
    chk_tbl[4]  = '{8, 0, 24'hFFFFFF};  chk_tbl[5]  = '{11, 0, 24'hFFFFFF};
    chk_tbl[6]  = '{0, 4, 24'h000000};  chk_tbl[7]  = '{4, 4, 24'hFFFFFF};
    chk_tbl[8]  = '{8, 4, 24'h000000};  chk_tbl[9]  = '{12, 4, 24'hFFFFFF};
    chk_tbl[10] = '{5, 5, 24'hFFFFFF};  chk_tbl[11] = '{16, 0, 24'h000000};

    bar_mask_tbl[0] = 16'h00F0;
    bar_mask_tbl[1] = 16'h0F00;
    bar_mask_tbl[2] = 16'hF000;
    bar_mask_tbl[3] = 16'h000F;

    // Reset state
    @(posedge clk);
    #1;
    check("reset_de", de, 1'b0);
    check("reset_hsync", hsync, 1'b0);
    check("reset_vsync", vsync, 1'b0);
    check("reset_rgb", {r, g, b}, 24'h0);

    // Frame 0: colour bars; pattern=2 requested mid-frame at (5,3)
    @(negedge clk);
    resetn = 1'b1;
    run_frame(FRAME, 4'd2, 3 * HT + 5);
    check_bars_line0("f0");
    check("f0_after_req_6_5", cap_rgb[5][6], 24'h00FF00);
    check("f0_after_req_15_7", cap_rgb[7][15], 24'h000000);
    check("f0_after_req_0_7", cap_rgb[7][0], 24'hFFFFFF);
    check_raster("f0");

    // Frame 1: solid red; request pattern 12
    run_frame(FRAME, 4'd12, 100);
    begin
      int bad = 0;
      for (int v = 0; v < 8; v++)
        for (int h = 0; h < 16; h++)
          if (cap_rgb[v][h] !== 24'hFF0000) bad++;
      check("f1_red_pixels_wrong", bad, 0);
    end
    check("f1_first_pixel", cap_rgb[0][0], 24'hFF0000);
    check_raster("f1");

    // Frame 2: pattern 12 -> black; request checkerboard
    run_frame(FRAME, 4'd7, 50);
    begin
      int bad = 0;
      for (int v = 0; v < VT; v++)
        for (int h = 0; h < HT; h++)
          if (cap_rgb[v][h] !== 24'h0) bad++;
      check("f2_black_nonzero", bad, 0);
    end
    check_raster("f2");

    // Frame 3: checkerboard; request ramp
    run_frame(FRAME, 4'd6, 50);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("f3_chk_h%0d_v%0d", chk_tbl[i].h, chk_tbl[i].v),
            cap_rgb[chk_tbl[i].v][chk_tbl[i].h], chk_tbl[i].rgb);
    end

    // Frame 4: grey ramp, stopped at pixel (10,5) for a mid-frame reset
    run_frame(5 * HT + 10 + 1, 4'd6, -1);
    begin
      int bad = 0;
      logic [7:0] hb;
      for (int i = 0; i <= 5 * HT + 10; i++) begin
        if ((i % HT) < 16 && (i / HT) < 8) begin
          hb = 8'(i % HT);
          if (cap_rgb[i / HT][i % HT] !== {hb, hb, hb}) bad++;
        end
      end
      check("f4_ramp_wrong", bad, 0);
    end
    check("f4_pix_10_5", {de, r, g, b}, {1'b1, 24'h0A0A0A});

    // Mid-frame reset: outputs clear immediately, pattern input ignored on restart
    pattern = 4'd8;
    resetn = 1'b0;
    #1;
    check("midrst_de", de, 1'b0);
    check("midrst_rgb", {r, g, b}, 24'h0);
    check("midrst_sync", {hsync, vsync}, 2'b00);
    @(posedge clk);
    #1;
    check("midrst_held", {de, hsync, vsync, r, g, b}, 27'h0);
    @(negedge clk);
    resetn = 1'b1;
    run_frame(FRAME, 4'd8, -1);
    check_bars_line0("restart");
    check_raster("restart");

    // Moving bar frames: bar_pos already advanced at the first pattern-8 frame
    for (int f = 0; f < 4; f++) begin
      logic [15:0] m0;
      logic [15:0] m7;
      int other;
      run_frame(FRAME, 4'd8, -1);
      m0 = '0;
      m7 = '0;
      other = 0;
      for (int h = 0; h < 16; h++) begin
        m0[h] = (cap_rgb[0][h] === 24'hFFFFFF);
        m7[h] = (cap_rgb[7][h] === 24'hFFFFFF);
        if (cap_rgb[0][h] !== 24'hFFFFFF && cap_rgb[0][h] !== 24'h0) other++;
      end
      check($sformatf("bar_f%0d_line0", f), m0, bar_mask_tbl[f]);
      check($sformatf("bar_f%0d_line7", f), m7, bar_mask_tbl[f]);
      check($sformatf("bar_f%0d_other_colour", f), other, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
